// File: rtl/can_tx_loader_if.sv
// Message handshake, status and register-bus signals between the CAN transmit loader and its neighbours.
// master: the loader side; slave: message source plus controller register file.
`timescale 1ns/1ps
interface can_tx_loader_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [28:0] msg_id;
    logic        msg_ext;
    logic        msg_rtr;
    logic [3:0]  msg_dlc;
    logic [63:0] msg_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cs;
    logic        read_n;
    logic        write_n;
    logic [4:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        input  msg_valid, msg_id, msg_ext, msg_rtr, msg_dlc, msg_data, readdata,
        output msg_ready, busy, done, error, cs, read_n, write_n, address, writedata
    );

    modport slave (
        output msg_valid, msg_id, msg_ext, msg_rtr, msg_dlc, msg_data, readdata,
        input  msg_ready, busy, done, error, cs, read_n, write_n, address, writedata
    );
endinterface

// File: rtl/can_tx_loader.sv
// CAN transmit loader: writes TRAAR1, TRAAR2, the needed TRADxx words and TRACON(TREQ) per accepted message.
// Define CAN_TX_LOADER_POLL_DONE_EN to poll TRACON until TREQ clears (bounded by POLL_TIMEOUT reads).
`timescale 1ns/1ps
module can_tx_loader #(
    parameter logic [4:0] ADDR_TRACON  = 5'd3,
    parameter logic [4:0] ADDR_TRAAR1  = 5'd4,
    parameter logic [4:0] ADDR_TRAAR2  = 5'd5,
    parameter logic [4:0] ADDR_TRAD01  = 5'd6,
    parameter int         TREQ_BIT     = 15,
    parameter int         POLL_TIMEOUT = 255
) (
    input logic             clk_i,
    input logic             rst_ni,
    can_tx_loader_if.master bus_if
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AR1  = 3'd1,
        S_WR_AR2  = 3'd2,
        S_WR_DATA = 3'd3,
        S_WR_CON  = 3'd4,
        S_POLL    = 3'd5,
        S_FIN     = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [1:0]  idx_q, idx_d;
    logic [28:0] id_q, id_d;
    logic        ext_q, ext_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic [2:0]  nwords_q, nwords_d;

    logic        msg_ready_q, msg_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cs_q, cs_d;
    logic        read_n_q, read_n_d;
    logic        write_n_q, write_n_d;
    logic [4:0]  address_q, address_d;
    logic [15:0] writedata_q, writedata_d;

    logic [3:0]  dlc_eff_s;
    logic [2:0]  nwords_s;
    logic        strobe_s;

`ifdef CAN_TX_LOADER_POLL_DONE_EN
    localparam int             PCW       = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_TIMEOUT - 1);
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
`else
    logic unused_s;
    assign unused_s = ^{bus_if.readdata, POLL_TIMEOUT[0]};
`endif

    // Data word k carries bytes 2k and 2k+1; a byte beyond the data length goes out as zero
    function automatic logic [15:0] data_word(input logic [63:0] data, input logic [1:0] idx,
                                              input logic [3:0] dlc);
        logic [63:0] sh;
        logic [3:0]  lo_pos;
        sh     = data << {idx, 4'b0000};
        lo_pos = {1'b0, idx, 1'b1};
        return {sh[63:56], (lo_pos < dlc) ? sh[55:48] : 8'h00};
    endfunction

    function automatic logic [15:0] con_word(input logic rtr, input logic ext, input logic [3:0] dlc);
        logic [15:0] w;
        w           = 16'h0000;
        w[TREQ_BIT] = 1'b1;
        w[5]        = rtr;
        w[4]        = ext;
        w[3:0]      = dlc;
        return w;
    endfunction

    assign dlc_eff_s = (bus_if.msg_dlc > 4'd8) ? 4'd8 : bus_if.msg_dlc;
    assign nwords_s  = dlc_eff_s[3:1] + {2'b00, dlc_eff_s[0]};

    // Sequencer next state, message capture and poll bookkeeping
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        id_d     = id_q;
        ext_d    = ext_q;
        rtr_d    = rtr_q;
        dlc_d    = dlc_q;
        data_d   = data_q;
        nwords_d = nwords_q;
        error_d  = 1'b0;
`ifdef CAN_TX_LOADER_POLL_DONE_EN
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus_if.msg_valid && msg_ready_q) begin
                    id_d     = bus_if.msg_id;
                    ext_d    = bus_if.msg_ext;
                    rtr_d    = bus_if.msg_rtr;
                    dlc_d    = dlc_eff_s;
                    data_d   = bus_if.msg_data;
                    nwords_d = bus_if.msg_rtr ? 3'd0 : nwords_s;
                    idx_d    = 2'd0;
                    phase_d  = 1'b0;
                    state_d  = S_WR_AR1;
`ifdef CAN_TX_LOADER_POLL_DONE_EN
                    poll_cnt_d = {PCW{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_AR1: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_WR_AR2;
                end
            end
            S_WR_AR2: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (nwords_q != 3'd0) begin
                    phase_d = 1'b0;
                    state_d = S_WR_DATA;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_WR_CON;
                end
            end
            S_WR_DATA: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if ({1'b0, idx_q} == (nwords_q - 3'd1)) begin
                    phase_d = 1'b0;
                    state_d = S_WR_CON;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    phase_d = 1'b0;
                end
            end
            S_WR_CON: begin
`ifdef CAN_TX_LOADER_POLL_DONE_EN
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_POLL;
                end
`else
                // Without polling, FIN doubles as the TRACON gap cycle
                phase_d = 1'b0;
                state_d = S_FIN;
`endif
            end
            S_POLL: begin
`ifdef CAN_TX_LOADER_POLL_DONE_EN
                if (phase_q) begin
                    phase_d = 1'b0;
                end else if (!bus_if.readdata[TREQ_BIT]) begin
                    state_d = S_FIN;
                end else if (poll_cnt_q == POLL_LAST) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    poll_cnt_d = poll_cnt_q + PCW'(1'b1);
                    phase_d    = 1'b1;
                end
`else
                phase_d = 1'b0;
                state_d = S_IDLE;
`endif
            end
            S_FIN: begin
                phase_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                phase_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs are computed from the upcoming state so they can be registered
    always_comb begin
        strobe_s    = !phase_d && (state_d inside {S_WR_AR1, S_WR_AR2, S_WR_DATA, S_WR_CON, S_POLL});
        msg_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        cs_d        = strobe_s;
        write_n_d   = !(strobe_s && (state_d != S_POLL));
        read_n_d    = !(strobe_s && (state_d == S_POLL));
        case (state_d)
            S_WR_AR1: begin
                address_d   = ADDR_TRAAR1;
                writedata_d = id_d[28:13];
            end
            S_WR_AR2: begin
                address_d   = ADDR_TRAAR2;
                writedata_d = {id_d[12:0], 3'b000};
            end
            S_WR_DATA: begin
                address_d   = ADDR_TRAD01 + {3'b000, idx_d};
                writedata_d = data_word(data_d, idx_d, dlc_d);
            end
            S_WR_CON: begin
                address_d   = ADDR_TRACON;
                writedata_d = con_word(rtr_d, ext_d, dlc_d);
            end
            S_POLL: begin
                address_d   = ADDR_TRACON;
                writedata_d = 16'h0000;
            end
            default: begin
                address_d   = 5'd0;
                writedata_d = 16'h0000;
            end
        endcase
    end

    // State, captured message and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            idx_q       <= 2'd0;
            id_q        <= 29'd0;
            ext_q       <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= 4'd0;
            data_q      <= 64'd0;
            nwords_q    <= 3'd0;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cs_q        <= 1'b0;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            address_q   <= 5'd0;
            writedata_q <= 16'h0000;
`ifdef CAN_TX_LOADER_POLL_DONE_EN
            poll_cnt_q  <= {PCW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            ext_q       <= ext_d;
            rtr_q       <= rtr_d;
            dlc_q       <= dlc_d;
            data_q      <= data_d;
            nwords_q    <= nwords_d;
            msg_ready_q <= msg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cs_q        <= cs_d;
            read_n_q    <= read_n_d;
            write_n_q   <= write_n_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
`ifdef CAN_TX_LOADER_POLL_DONE_EN
            poll_cnt_q  <= poll_cnt_d;
`endif
        end
    end

    assign bus_if.msg_ready = msg_ready_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.done      = done_q;
    assign bus_if.error     = error_q;
    assign bus_if.cs        = cs_q;
    assign bus_if.read_n    = read_n_q;
    assign bus_if.write_n   = write_n_q;
    assign bus_if.address   = address_q;
    assign bus_if.writedata = writedata_q;

endmodule
